// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store stage and the word-wide data memory.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage: byte-lane steering, sign-extending loads, stall until ack or timeout.
// Min latency 2 stall cycles (IDLE + one BUSY); memory backpressure simply extends BUSY.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  sig_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  load_store_unit_if.master dmem
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        access, mis_c, stall_c, misalign_c, bus_err_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ext_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    access = (mem_read | mem_write) && (sig_size != 2'b11);
    mis_c  = ((sig_size == 2'b01) && addr[0]) ||
             ((sig_size == 2'b10) && (addr[1:0] != 2'b00));
    case (sig_size)
      2'b00:   begin be_c = 4'b0001 << addr[1:0];             wdata_c = {4{store_data[7:0]}};  end
      2'b01:   begin be_c = addr[1] ? 4'b1100 : 4'b0011;      wdata_c = {2{store_data[15:0]}}; end
      default: begin be_c = 4'b1111;                          wdata_c = store_data;            end
    endcase
  end

  // Lane extraction uses the latched offset/size, never the live inputs.
  always_comb begin
    case (off_q)
      2'd0:    byte_c = dmem.dmem_rdata[7:0];
      2'd1:    byte_c = dmem.dmem_rdata[15:8];
      2'd2:    byte_c = dmem.dmem_rdata[23:16];
      default: byte_c = dmem.dmem_rdata[31:24];
    endcase
    half_c = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (size_q)
      2'b00:   ext_c = {{24{byte_c[7]}}, byte_c};
      2'b01:   ext_c = {{16{half_c[15]}}, half_c};
      default: ext_c = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    off_d       = off_q;
    stall_c     = 1'b0;
    misalign_c  = 1'b0;
    bus_err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && rst_n) begin
          if (mis_c) begin
            misalign_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = mem_write ? be_c : 4'b0000;
            wdata_d = wdata_c;
            size_d  = sig_size;
            off_d   = addr[1:0];
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (dmem.dmem_ack) begin
          if (!we_q) load_data_d = ext_c;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          bus_err_c   = 1'b1;
          load_data_d = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_data_q <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b11;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      off_q       <= off_d;
    end
  end

  assign stall           = stall_c;
  assign misalign        = misalign_c;
  assign bus_err         = bus_err_c;
  assign load_data       = misalign_c ? 32'h0 : load_data_q;
  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors checked with immediate assertions.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [1:0]  sig_size;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, misalign, bus_err;
  int          vectors = 0;
  int          errs = 0;

  load_store_unit_if dmem();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .sig_size   (sig_size),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dmem       (dmem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] sd);
    mem_read = rd; mem_write = wr; sig_size = sz; addr = a; store_data = sd;
  endtask

  initial begin
    rst_n = 1'b0;
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = 32'h0;
    drive(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(dmem.dmem_req), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_addr", dmem.dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem.dmem_be), 32'h0);
    chk("rst_wdata", dmem.dmem_wdata, 32'h0);
    chk("rst_we", 32'(dmem.dmem_we), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LB 0x103, ack in first BUSY cycle
    step();
    drive(1'b1, 1'b0, 2'b00, 32'h103, 32'h0);
    #1 chk("lb_c0_stall", 32'(stall), 32'h1);
    chk("lb_c0_req", 32'(dmem.dmem_req), 32'h0);
    step();
    dmem.dmem_rdata = 32'h8000_0000; dmem.dmem_ack = 1'b1;
    #1 chk("lb_c1_stall", 32'(stall), 32'h1);
    chk("lb_c1_req", 32'(dmem.dmem_req), 32'h1);
    chk("lb_addr", dmem.dmem_addr, 32'h100);
    chk("lb_be", 32'(dmem.dmem_be), 32'h0);
    chk("lb_we", 32'(dmem.dmem_we), 32'h0);
    step();
    dmem.dmem_ack = 1'b0;
    #1 chk("lb_done_stall", 32'(stall), 32'h0);
    chk("lb_done_req", 32'(dmem.dmem_req), 32'h0);
    chk("lb_load_data", load_data, 32'hFFFF_FF80);
    step();
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h1111_1111;
    #1 chk("idle_stall", 32'(stall), 32'h0);
    step();
    dmem.dmem_ack = 1'b0;
    #1 chk("stray_ack_ignored", load_data, 32'hFFFF_FF80);

    // SH 0x202, three wait states
    step();
    drive(1'b0, 1'b1, 2'b01, 32'h202, 32'h1234_ABCD);
    #1 chk("sh_c0_stall", 32'(stall), 32'h1);
    step();
    #1 chk("sh_c1_stall", 32'(stall), 32'h1);
    chk("sh_be", 32'(dmem.dmem_be), 32'hC);
    chk("sh_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dmem.dmem_we), 32'h1);
    chk("sh_addr", dmem.dmem_addr, 32'h200);
    step();
    drive(1'b1, 1'b0, 2'b10, 32'h5554, 32'h0);
    #1 chk("sh_c2_stall", 32'(stall), 32'h1);
    chk("sh_hold_addr", dmem.dmem_addr, 32'h200);
    chk("sh_hold_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    step();
    #1 chk("sh_c3_stall", 32'(stall), 32'h1);
    step();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("sh_c4_stall", 32'(stall), 32'h1);
    step();
    dmem.dmem_ack = 1'b0;
    drive(1'b0, 1'b1, 2'b01, 32'h202, 32'h1234_ABCD);
    #1 chk("sh_done_stall", 32'(stall), 32'h0);
    chk("sh_load_data", load_data, 32'hFFFF_FF80);

    // SB 0x13: top lane
    step();
    drive(1'b0, 1'b1, 2'b00, 32'h13, 32'h0000_00A5);
    #1 chk("sb_c0_stall", 32'(stall), 32'h1);
    step();
    dmem.dmem_ack = 1'b1;
    #1 chk("sb_be", 32'(dmem.dmem_be), 32'h8);
    chk("sb_wdata", dmem.dmem_wdata, 32'hA5A5_A5A5);
    step();
    dmem.dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    #1 chk("sb_done_stall", 32'(stall), 32'h0);

    // LW 0x006: misaligned
    step();
    drive(1'b1, 1'b0, 2'b10, 32'h6, 32'h0);
    #1 chk("mis_pulse", 32'(misalign), 32'h1);
    chk("mis_stall", 32'(stall), 32'h0);
    chk("mis_load_data", load_data, 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    #1 chk("mis_no_req", 32'(dmem.dmem_req), 32'h0);
    chk("mis_end", 32'(misalign), 32'h0);
    chk("mis_restore", load_data, 32'hFFFF_FF80);

    // LH 0x2, negative upper half
    step();
    drive(1'b1, 1'b0, 2'b01, 32'h2, 32'h0);
    step();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h8001_7FFF;
    step();
    dmem.dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    #1 chk("lh_load_data", load_data, 32'hFFFF_8001);

    // LH 0x0 with no ack: timeout after 16 BUSY cycles
    step();
    drive(1'b1, 1'b0, 2'b01, 32'h0, 32'h0);
    #1 chk("to_c0_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step();
      #1 chk("to_busy_stall", 32'(stall), 32'h1);
      chk("to_busy_bus_err", 32'(bus_err), (i == 15) ? 32'h1 : 32'h0);
    end
    step();
    #1 chk("to_done_stall", 32'(stall), 32'h0);
    chk("to_done_bus_err", 32'(bus_err), 32'h0);
    chk("to_load_data", load_data, 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    #1 chk("to_idle_req", 32'(dmem.dmem_req), 32'h0);

    // SW with reset asserted mid-BUSY
    step();
    drive(1'b0, 1'b1, 2'b10, 32'h300, 32'hCAFE_F00D);
    step();
    #1 chk("sw_busy_req", 32'(dmem.dmem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("arst_req", 32'(dmem.dmem_req), 32'h0);
    chk("arst_addr", dmem.dmem_addr, 32'h0);
    chk("arst_we", 32'(dmem.dmem_we), 32'h0);
    chk("arst_wdata", dmem.dmem_wdata, 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_bus_err", 32'(bus_err), 32'h0);
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // size 11 access, then LW 0x40 back-to-back
    step();
    drive(1'b1, 1'b0, 2'b11, 32'h40, 32'h0);
    #1 chk("none_stall", 32'(stall), 32'h0);
    chk("none_req", 32'(dmem.dmem_req), 32'h0);
    step();
    drive(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    #1 chk("lw_c0_stall", 32'(stall), 32'h1);
    step();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h7FFF_0001;
    #1 chk("lw_c1_req", 32'(dmem.dmem_req), 32'h1);
    step();
    dmem.dmem_ack = 1'b0;
    #1 chk("lw_done_stall", 32'(stall), 32'h0);
    chk("lw_load_data", load_data, 32'h7FFF_0001);
    step();
    drive(1'b1, 1'b0, 2'b00, 32'h41, 32'h0);
    #1 chk("b2b_stall", 32'(stall), 32'h1);
    step();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h0000_7F00;
    step();
    dmem.dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    #1 chk("b2b_load_data", load_data, 32'h0000_007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the datapath (ALU result, rt operand, decoder memory controls) and a word-wide data memory with a request/acknowledge handshake. Executes LB/LH/LW/SB/SH/SW as selected by `mem_read`/`mem_write`/`sig_size` from the control unit. Generates byte enables, aligns store data, and sign-extends loads. Stalls the single-cycle core until the memory acknowledges, and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, 16: BUSY cycles without `dmem_ack` before a bus error is declared (≥2).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: load request (decoder MemRead).
- `mem_write` in 1: store request (decoder MemWrite).
- `sig_size` in 2: access size: 00 byte, 01 half, 10 word, 11 none.
- `addr` in 32: byte address (ALU result).
- `store_data` in 32: rt value; the low byte/half is used for sub-word stores.
- `load_data` out 32: sign-extended load result, registered.
- `stall` out 1: core must hold PC and all state this cycle.
- `misalign` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on a timeout.
- `dmem_req` out 1: memory request, held until ack.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `dmem_be` out 4: byte enables; lane i = bits 8i+7:8i.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: read data, valid with ack.
- `dmem_ack` in 1: completes the outstanding request.

## Operation
- Access = (`mem_read` | `mem_write`) & `sig_size`≠11. If both strobes are high, `mem_write` wins.
- Little-endian lanes. BE: byte `4'b0001<<addr[1:0]`; half `addr[1]?1100:0011`; word `1111`.
- `dmem_wdata`: byte `{4{sd[7:0]}}`; half `{2{sd[15:0]}}`; word `sd`.
- Load extract: select the lane byte or half from `dmem_rdata` by `addr[1:0]`, sign-extend to 32 bits. Word loads pass through unchanged.
- Misaligned: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No memory request is issued.
  - `misalign` pulses, `stall` stays 0, and `load_data` is forced to 0 the same cycle (combinational override).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: an aligned access drives `stall`=1. The address, BE, wdata, size, and `we` are latched, the timeout counter is cleared, and the FSM goes to BUSY.
  - BUSY: `dmem_req`=1 with the latched fields held stable, and `stall`=1.
    - On `dmem_ack`: capture the extracted read data into `load_data` (write: `load_data` unchanged) and go to DONE.
    - If the counter reaches `TIMEOUT_CYCLES`-1 without ack: pulse `bus_err`, set `load_data`=0, and go to DONE.
  - DONE: `stall`=0 and `dmem_req`=0, so the core commits. The FSM returns to IDLE unconditionally. The access still visible on the inputs this cycle is ignored.
- Inputs change while in BUSY: ignored, because the latched copy is used.
- `dmem_ack` outside BUSY: ignored.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `load_data`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0, `misalign`=0, `bus_err`=0.
- `stall` is 0 in reset; after release it follows the combinational IDLE decode.
- Reset asserted during BUSY aborts the request immediately (`dmem_req` drops asynchronously). No completion is reported.
- Ack in the first BUSY cycle gives the minimum latency: C0 IDLE (stall), C1 BUSY+ack (stall), C2 DONE (stall=0, `load_data` valid). The stall lasts 2 cycles.
- Each extra wait state adds one stall cycle.
- A timeout produces stall for 1+`TIMEOUT_CYCLES` cycles, with `bus_err` high in the last BUSY cycle.
- Back-to-back accesses: the next access is recognised in the cycle after DONE.
- Counter width is `$clog2(TIMEOUT_CYCLES)`. It saturates and never wraps.

## Test plan
- LB at addr 0x103, rdata 0x80_00_00_00, ack in the first BUSY cycle → `dmem_addr`=0x100, `be`=0000 (read), stall high exactly 2 cycles, `load_data`=0xFFFFFF80 in DONE.
- SH at addr 0x202, sd=0x1234ABCD, ack after 3 wait states → `be`=1100, `wdata`=0xABCDABCD, `we`=1, stall high 5 cycles, `load_data` unchanged.
- LW at addr 0x006 → `misalign` 1-cycle pulse, `dmem_req` never asserts, `stall`=0, `load_data`=0.
- LH at addr 0x0 with no ack and `TIMEOUT_CYCLES`=16 → `bus_err` pulses after 16 BUSY cycles, `load_data`=0, then IDLE.
- `rst_n` low during BUSY of a SW → `dmem_req` falls without waiting for a clock edge, all outputs at reset values, no `bus_err`.
- `sig_size`=11 with `mem_read`=1, then LW 0x40 (rdata 0x7FFF0001) back-to-back → first: no stall, no request; second: `load_data`=0x7FFF0001, next access accepted the cycle after DONE.
